// File: rtl/output_port_scheduler.sv
// Four-input wormhole output scheduler: round-robin grant on packet heads,
// packet lock until tail, and credit-based flow control toward the downstream buffer.
module output_port_scheduler #(
  parameter int flitWidth = 8,
  parameter int CREDITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_valid,
  input  logic [3:0]           in_head,
  input  logic [3:0]           in_tail,
  input  logic [flitWidth-1:0] in_flit0,
  input  logic [flitWidth-1:0] in_flit1,
  input  logic [flitWidth-1:0] in_flit2,
  input  logic [flitWidth-1:0] in_flit3,
  input  logic                 credit_return,
  output logic [3:0]           port_block,
  output logic [1:0]           mux_select,
  output logic                 out_valid,
  output logic [flitWidth-1:0] out_flit,
  output logic                 busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           ptr_reg, ptr_next;
  logic [1:0]           sel_reg, sel_next;
  logic [3:0]           credit_reg, credit_next;
  logic                 out_valid_reg;
  logic [flitWidth-1:0] out_flit_reg;

  logic [3:0][flitWidth-1:0] flits;
  logic [3:0]                cand;
  logic [1:0]                order [4];
  logic [3:0]                rot_cand;
  logic [1:0]                winner;
  logic                      xfer;

  assign flits = {in_flit3, in_flit2, in_flit1, in_flit0};
  assign cand  = in_valid & in_head;
  assign xfer  = (state_reg == LOCKED) && in_valid[sel_reg] && (credit_reg != 4'd0);

  // order[k] is the k-th port visited by the round-robin search starting after ptr
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      assign order[gi]      = ptr_reg + 2'(gi + 1);
      assign rot_cand[gi]   = cand[order[gi]];
      assign port_block[gi] = !(xfer && (sel_reg == 2'(gi)));
    end
  endgenerate

  always_comb begin
    winner = order[0];
    for (int i = 3; i >= 0; i--) begin
      if (rot_cand[i]) winner = order[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|cand) begin
          state_next = LOCKED;
          sel_next   = winner;
        end
      end
      LOCKED: begin
        if (xfer && in_tail[sel_reg]) begin
          state_next = IDLE;
          ptr_next   = sel_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A returned credit at full count is dropped; simultaneous use and return cancel
  always_comb begin
    credit_next = credit_reg;
    case ({xfer, credit_return})
      2'b10:   credit_next = credit_reg - 4'd1;
      2'b01:   if (credit_reg != 4'(CREDITS)) credit_next = credit_reg + 4'd1;
      default: credit_next = credit_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd3;
      sel_reg       <= 2'd0;
      credit_reg    <= 4'(CREDITS);
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      sel_reg       <= sel_next;
      credit_reg    <= credit_next;
      out_valid_reg <= xfer;
      if (xfer) out_flit_reg <= flits[sel_reg];
    end
  end

  assign mux_select = sel_reg;
  assign out_valid  = out_valid_reg;
  assign out_flit   = out_flit_reg;
  assign busy       = (state_reg == LOCKED);

endmodule
